target_generator: RTL
=====================

# target_generator

Places the snake's food target on the playfield grid and detects when the snake head lands on it. Sits directly upstream of the score counter: its one-cycle `TARGET_REACHED` pulse is the score counter's increment enable, and its `TARGET_X`/`TARGET_Y` feed the VGA pixel colouring logic. Relocation uses free-running LFSRs with rejection sampling, so the target never lands outside the grid or under the head.

## Interface

Parameters:
- `X_WIDTH`, 8, width of the X coordinate
- `Y_WIDTH`, 7, width of the Y coordinate
- `X_MAX`, 159, largest legal X
- `Y_MAX`, 119, largest legal Y
- `X_INIT`, 80, target X after reset
- `Y_INIT`, 60, target Y after reset
- `TIMEOUT_TICKS`, 64, game ticks before an uneaten target moves (only with the macro defined)

Ports:
- `CLK`  in  1  system clock; single clock domain
- `RESET`  in  1  asynchronous, active-high reset
- `GAME_ACTIVE`  in  1  high while the game is running
- `HEAD_VALID`  in  1  one-cycle strobe: the head has moved and `HEAD_X`/`HEAD_Y` hold its new position
- `HEAD_X`  in  X_WIDTH  head column
- `HEAD_Y`  in  Y_WIDTH  head row
- `GAME_TICK`  in  1  one-cycle strobe per snake step; used only by the timeout feature
- `TARGET_X`  out  X_WIDTH  current target column, registered
- `TARGET_Y`  out  Y_WIDTH  current target row, registered
- `TARGET_VALID`  out  1  target is placed and should be drawn
- `TARGET_REACHED`  out  1  one-cycle pulse per target eaten

## Operation

- LFSRs:
  - X LFSR: 8 bits, Fibonacci, taps 8,6,5,4, seed 8'hA5.
  - Y LFSR: 7 bits, taps 7,6, seed 7'h2B.
  - Both advance every clock regardless of state. They never hold zero, so row 0 and column 0 are never chosen; these form the border wall.
- State machine, two states:
  - ARMED: target valid.
    - If `GAME_ACTIVE` and `HEAD_VALID` are high and `HEAD_X==TARGET_X` and `HEAD_Y==TARGET_Y`, assert `TARGET_REACHED`, clear `TARGET_VALID` and go to RELOCATE.
  - RELOCATE: each cycle, sample `{xlfsr, ylfsr}` and test the candidate.
    - Accept it if `x<=X_MAX`, `y<=Y_MAX` and the candidate is not equal to the current `{HEAD_X,HEAD_Y}`.
    - On accept: load `TARGET_X`/`TARGET_Y`, set `TARGET_VALID`, go to ARMED.
    - On reject: stay in RELOCATE and retry next cycle.
- `HEAD_VALID` is ignored in RELOCATE, so one target cannot be eaten twice.
- `GAME_ACTIVE` low blocks hit detection and the timeout. A relocation already in progress still completes.
- Comparison width: X is compared at `X_WIDTH`; Y uses the low `Y_WIDTH` bits of the LFSR.

## Timing

- Reset values:
  - state ARMED
  - `TARGET_X`=`X_INIT`, `TARGET_Y`=`Y_INIT`
  - `TARGET_VALID`=1, `TARGET_REACHED`=0
  - LFSRs at their seeds
  - timeout counter 0
- Hit latency: `HEAD_VALID` sampled at edge N. `TARGET_REACHED` is high for exactly the cycle after edge N, and `TARGET_VALID` falls at edge N.
- Relocation takes at least 1 cycle. The new target is valid at the first accepting edge after entering RELOCATE. The acceptance rate is about 0.59, so this is typically 1–3 cycles.
- `TARGET_REACHED` is never high for two consecutive cycles.
- `RESET` asserted during RELOCATE: all outputs return to their reset values asynchronously, and no pulse is emitted.

## Configuration

- Macro `TARGET_TIMEOUT_EN`.
- Defined:
  - A counter wide enough for `TIMEOUT_TICKS` counts `GAME_TICK` strobes while in ARMED with `GAME_ACTIVE` high.
  - The counter clears on every entry to ARMED.
  - When the count reaches `TIMEOUT_TICKS`, go to RELOCATE and clear `TARGET_VALID`, without pulsing `TARGET_REACHED`.
  - If a hit and the timeout occur in the same cycle, the hit wins and the pulse is emitted.
- Undefined: no counter is built, the target stays until eaten, and `GAME_TICK` is unused.

## Test plan

- Reset, then hold idle → `TARGET_X`=80, `TARGET_Y`=60, `TARGET_VALID`=1 and `TARGET_REACHED`=0 for 100 cycles.
- `GAME_ACTIVE`=1, one `HEAD_VALID` strobe with head (80,60) → exactly one `TARGET_REACHED` cycle. `TARGET_VALID` returns high within 16 cycles at a position with 1≤x≤159, 1≤y≤119, not equal to (80,60).
- Head (80,60) with `HEAD_VALID` held high for 10 cycles → exactly one pulse. Repeat on each new target 20 times → 20 pulses, and every placement is in range.
- `GAME_ACTIVE`=0, head on target with `HEAD_VALID` strobing → no pulse, target unchanged.
- Hit, then assert `RESET` mid-RELOCATE → outputs (80,60,1,0) immediately, no pulse after release.
- With `TARGET_TIMEOUT_EN` defined and `TIMEOUT_TICKS`=4, send 4 `GAME_TICK`s and no hit → target moves with no pulse. Then apply a hit on the same cycle as the 4th tick → one pulse.

Source files
------------

// File: rtl/target_generator.sv
// rtl/target_generator.sv - snake food target placement and hit detection
// Optional macro TARGET_TIMEOUT_EN relocates an uneaten target after TIMEOUT_TICKS game ticks.
module target_generator #(
    parameter int X_WIDTH       = 8,
    parameter int Y_WIDTH       = 7,
    parameter int X_MAX         = 159,
    parameter int Y_MAX         = 119,
    parameter int X_INIT        = 80,
    parameter int Y_INIT        = 60,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               GAME_ACTIVE,
    input  logic               HEAD_VALID,
    input  logic [X_WIDTH-1:0] HEAD_X,
    input  logic [Y_WIDTH-1:0] HEAD_Y,
    input  logic               GAME_TICK,
    output logic [X_WIDTH-1:0] TARGET_X,
    output logic [Y_WIDTH-1:0] TARGET_Y,
    output logic               TARGET_VALID,
    output logic               TARGET_REACHED
);

    typedef enum logic {ST_ARMED, ST_RELOCATE} state_t;

    localparam logic [X_WIDTH-1:0] LP_X_MAX  = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0] LP_Y_MAX  = Y_WIDTH'(Y_MAX);
    localparam logic [X_WIDTH-1:0] LP_X_INIT = X_WIDTH'(X_INIT);
    localparam logic [Y_WIDTH-1:0] LP_Y_INIT = Y_WIDTH'(Y_INIT);

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_xlfsr;
    logic [6:0]         r_ylfsr;
    logic [X_WIDTH-1:0] r_tx;
    logic [Y_WIDTH-1:0] r_ty;
    logic               r_valid;
    logic               r_reached;
    logic [X_WIDTH-1:0] w_tx_next;
    logic [Y_WIDTH-1:0] w_ty_next;
    logic               w_valid_next;
    logic               w_reached_next;
    logic [X_WIDTH-1:0] w_cand_x;
    logic [Y_WIDTH-1:0] w_cand_y;
    logic               w_hit;
    logic               w_accept;
    logic               w_timeout;

    assign w_cand_x = X_WIDTH'(r_xlfsr);
    assign w_cand_y = Y_WIDTH'(r_ylfsr);

    assign w_hit    = GAME_ACTIVE && HEAD_VALID && (HEAD_X == r_tx) && (HEAD_Y == r_ty);
    assign w_accept = (w_cand_x <= LP_X_MAX) && (w_cand_y <= LP_Y_MAX) &&
                      !((w_cand_x == HEAD_X) && (w_cand_y == HEAD_Y));

`ifdef TARGET_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = GAME_ACTIVE && GAME_TICK && (r_state == ST_ARMED) &&
                       (r_cnt == CNT_W'(TIMEOUT_TICKS - 1));

    // Held at zero outside ARMED so every entry to ARMED starts a fresh count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (r_state != ST_ARMED) begin
            r_cnt <= '0;
        end else if (GAME_ACTIVE && GAME_TICK) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tick;
    assign w_unused_tick = GAME_TICK;
    assign w_timeout     = 1'b0;
`endif

    // Both LFSRs free-run so the candidate stream does not depend on game state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_xlfsr <= 8'hA5;
            r_ylfsr <= 7'h2B;
        end else begin
            r_xlfsr <= {r_xlfsr[6:0], r_xlfsr[7] ^ r_xlfsr[5] ^ r_xlfsr[4] ^ r_xlfsr[3]};
            r_ylfsr <= {r_ylfsr[5:0], r_ylfsr[6] ^ r_ylfsr[5]};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_ARMED;
            r_tx      <= LP_X_INIT;
            r_ty      <= LP_Y_INIT;
            r_valid   <= 1'b1;
            r_reached <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tx      <= w_tx_next;
            r_ty      <= w_ty_next;
            r_valid   <= w_valid_next;
            r_reached <= w_reached_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_tx_next      = r_tx;
        w_ty_next      = r_ty;
        w_valid_next   = r_valid;
        w_reached_next = 1'b0;
        case (r_state)
            ST_ARMED: begin
                if (w_hit) begin
                    w_reached_next = 1'b1;
                    w_valid_next   = 1'b0;
                    w_state_next   = ST_RELOCATE;
                end else if (w_timeout) begin
                    w_valid_next   = 1'b0;
                    w_state_next   = ST_RELOCATE;
                end
            end
            ST_RELOCATE: begin
                if (w_accept) begin
                    w_tx_next    = w_cand_x;
                    w_ty_next    = w_cand_y;
                    w_valid_next = 1'b1;
                    w_state_next = ST_ARMED;
                end
            end
            default: w_state_next = ST_ARMED;
        endcase
    end

    assign TARGET_X       = r_tx;
    assign TARGET_Y       = r_ty;
    assign TARGET_VALID   = r_valid;
    assign TARGET_REACHED = r_reached;

endmodule
